bcd_to_bin_13bit: RTL and testbench

Sequential BCD-to-binary converter, the inverse of the timer's binary-to-BCD digit path. It accepts four BCD digits (thousands/hundreds/tens/ones) on a start pulse and converts them with reverse double-dabble: shift right, then subtract 3 from any digit >= 8, one shift per clock. It returns the binary value with a done pulse. It sits between keypad or stored-digit logic and the binary-domain timer (threshold and best-time compare).

---
 rtl/bcd_to_bin_13bit.sv | 182 ++++++++++++++++++
 tb/tb_bcd_to_bin_13bit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_13bit.sv
// bcd_to_bin_13bit
// Sequential four-digit BCD to binary converter using reverse double-dabble.
// A start pulse in IDLE loads the digits. Each SHIFT clock shifts {bcd, acc}
// right by one bit. After the shift, any BCD nibble that is >= 8 has 3
// subtracted from it. After N_SHIFT shifts the accumulator holds the binary
// value, which is registered on bin together with the ovf13 and err flags.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   conversion request, sampled only in IDLE
//   thousands  in   BCD digit, weight 1000
//   hundreds   in   BCD digit, weight 100
//   tens       in   BCD digit, weight 10
//   ones       in   BCD digit, weight 1
//   bin        out  binary result, held until the next completion
//   ovf13      out  result exceeds 8191 and does not fit 13 bits
//   err        out  last request contained a digit greater than 9
//   busy       out  conversion in progress (SHIFT state)
//   done       out  single-cycle completion pulse
module bcd_to_bin_13bit #(
    parameter int N_SHIFT = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         thousands,
    input  logic [3:0]         hundreds,
    input  logic [3:0]         tens,
    input  logic [3:0]         ones,
    output logic [N_SHIFT-1:0] bin,
    output logic               ovf13,
    output logic               err,
    output logic               busy,
    output logic               done
);

    localparam int VEC_W = 16 + N_SHIFT;
    localparam int CNT_W = $clog2(N_SHIFT);
    localparam logic [N_SHIFT-1:0] MAX13 = N_SHIFT'(8191);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [15:0]        bcd_q, bcd_d;
    logic [N_SHIFT-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_SHIFT-1:0] bin_q, bin_d;
    logic               ovf13_q, ovf13_d;
    logic               err_q, err_d;

    logic [VEC_W-1:0]   shifted;
    logic [15:0]        bcd_sh;
    logic [15:0]        bcd_fix;
    logic [N_SHIFT-1:0] acc_sh;
    logic               digits_ok;
    logic               cnt_last;

    // Reverse double-dabble correction. This undoes the +3 that the forward
    // algorithm applies to digits >= 5 before each left shift.
    function automatic logic [3:0] dab_fix(input logic [3:0] nib);
        return (nib >= 4'd8) ? (nib - 4'd3) : nib;
    endfunction

    function automatic logic digit_ok(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    assign digits_ok = digit_ok(thousands) && digit_ok(hundreds) &&
                       digit_ok(tens) && digit_ok(ones);

    assign cnt_last = (cnt_q == CNT_W'(N_SHIFT - 1));

    // BCD and accumulator are treated as one vector, so bcd[0] falls into the
    // accumulator MSB.
    always_comb begin
        shifted = {bcd_q, acc_q} >> 1;
        bcd_sh  = shifted[VEC_W-1:N_SHIFT];
        acc_sh  = shifted[N_SHIFT-1:0];
        bcd_fix = {dab_fix(bcd_sh[15:12]), dab_fix(bcd_sh[11:8]),
                   dab_fix(bcd_sh[7:4]),   dab_fix(bcd_sh[3:0])};
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = digits_ok ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        ovf13_d = ovf13_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (digits_ok) begin
                        bcd_d = {thousands, hundreds, tens, ones};
                        acc_d = '0;
                        cnt_d = '0;
                    end else begin
                        // Invalid digits skip conversion and report immediately.
                        bin_d   = '0;
                        ovf13_d = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                bcd_d = bcd_fix;
                acc_d = acc_sh;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    bin_d   = acc_sh;
                    ovf13_d = (acc_sh > MAX13);
                    err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            ovf13_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            ovf13_q <= ovf13_d;
            err_q   <= err_d;
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    assign bin   = bin_q;
    assign ovf13 = ovf13_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd_to_bin_13bit.sv
module tb_bcd_to_bin_13bit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  thousands, hundreds, tens, ones;
    logic [13:0] bin;
    logic        ovf13, err, busy, done;

    int checks = 0;
    int errors = 0;

    bcd_to_bin_13bit #(.N_SHIFT(14)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .bin       (bin),
        .ovf13     (ovf13),
        .err       (err),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one request at a negedge and follows it to completion. The
    // expected result comes from the decimal weights of the digits.
    task automatic convert(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        int  n;
        int  busy_cnt;
        int  val;
        bit  ok;
        ok  = (d3 <= 9) && (d2 <= 9) && (d1 <= 9) && (d0 <= 9);
        val = ok ? (int'(d3) * 1000 + int'(d2) * 100 + int'(d1) * 10 + int'(d0)) : 0;
        thousands = d3; hundreds = d2; tens = d1; ones = d0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        thousands = 4'($urandom_range(0, 15));
        hundreds  = 4'($urandom_range(0, 15));
        tens      = 4'($urandom_range(0, 15));
        ones      = 4'($urandom_range(0, 15));
        n = 0;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            n++;
            @(negedge clk);
        end
        // Edges from start sampling to done visible: 15 valid, 1 invalid.
        chk("latency", n + 1, ok ? 15 : 1);
        chk("busy_cycles", busy_cnt, ok ? 14 : 0);
        chk("bin", 32'(bin), val);
        chk("ovf13", 32'(ovf13), (val > 8191) ? 1 : 0);
        chk("err", 32'(err), ok ? 0 : 1);
        if (ok) chk("bcd_zero", 32'(dut.bcd_q), 0);
        @(negedge clk);
        chk("done_single", 32'(done), 0);
        chk("bin_held", 32'(bin), val);
    endtask

    task automatic convert_val(input int v);
        convert(4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10));
    endtask

    initial begin
        int first_done;
        int second_done;
        int pulses;
        int held_bin;
        reset = 1'b1;
        start = 1'b0;
        thousands = 0; hundreds = 0; tens = 0; ones = 0;
        #1;
        chk("rst_bin", 32'(bin), 0);
        chk("rst_ovf", 32'(ovf13), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed boundaries
        convert(0, 0, 0, 0);
        convert(9, 9, 9, 9);
        convert(8, 1, 9, 1);
        convert(8, 1, 9, 2);
        convert(0, 5, 4'hA, 3);
        convert(0, 0, 4, 2);
        convert(4'hF, 0, 0, 0);

        // Re-pulse start while busy, then hold start for a back-to-back run.
        thousands = 1; hundreds = 2; tens = 3; ones = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_done = 0;
        second_done = 0;
        pulses = 0;
        held_bin = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                thousands = 5; hundreds = 6; tens = 7; ones = 8;
                start = 1'b1;
            end
            if (done) begin
                pulses++;
                if (first_done == 0) begin
                    first_done = c;
                    held_bin = int'(bin);
                end else if (second_done == 0) begin
                    second_done = c;
                    chk("b2b_bin2", 32'(bin), 5678);
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        chk("restart_first_lat", first_done, 15);
        chk("restart_first_bin", held_bin, 1234);
        chk("b2b_spacing", second_done - first_done, 16);
        chk("done_pulses", pulses, 2);

        // Asynchronous reset in the middle of SHIFT
        thousands = 4; hundreds = 3; tens = 2; ones = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_bin", 32'(bin), 0);
        chk("mid_rst_ovf", 32'(ovf13), 0);
        chk("mid_rst_err", 32'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", pulses, 0);
        convert(0, 0, 0, 7);

        // Round trip of random binary values in the 13-bit domain
        for (int i = 0; i < 400; i++) begin
            convert_val(int'($urandom_range(0, 8191)));
        end
        // Full decimal range, including values above 8191
        for (int i = 0; i < 300; i++) begin
            convert_val(int'($urandom_range(0, 9999)));
        end
        // Arbitrary nibbles, including invalid digits
        for (int i = 0; i < 150; i++) begin
            convert(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
